button_switch_bus: RTL and testbench

Memory-mapped input peripheral: synchronises 8 slide switches, debounces 4 push-buttons, latches button-press events and presents all of it to the processor as readable bus registers. It is the read-side counterpart of the write-only LED display peripheral on the same 8-bit bus. It drives `BUS_DATA` only when the processor reads one of its addresses, and raises a processor interrupt on enabled button presses.

---
 rtl/button_switch_bus.sv | 142 ++++++++++++++
 tb/tb_button_switch_bus.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/button_switch_bus.sv
// Read-side bus peripheral: synchronised switches, debounced buttons, sticky press events
// and a maskable interrupt, exposed as a 4-byte register window on the 8-bit processor bus.
module button_switch_bus #(
  parameter logic [7:0]  BASE_ADDR       = 8'hC0,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  input  logic [7:0] SWITCHES,
  input  logic [3:0] BUTTONS,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] OffSwitch = 2'd0;
  localparam logic [1:0] OffEvent  = 2'd1;
  localparam logic [1:0] OffLevel  = 2'd2;
  localparam logic [1:0] OffMask   = 2'd3;

  logic [7:0]       r_sw_s1;
  logic [7:0]       r_sw_s2;
  logic [3:0]       r_btn_s1;
  logic [3:0]       r_btn_s2;
  logic [CNT_W-1:0] r_cnt [4];
  logic [3:0]       r_db;
  logic [3:0]       r_db_prev;
  logic [3:0]       r_evt;
  logic [3:0]       r_mask;
  logic             r_raise;
  logic [7:0]       r_rd_data;
  logic             r_rd_oe;

  logic [7:0] w_off;
  logic       w_in_win;
  logic       w_rd;
  logic       w_wr;
  logic [3:0] w_evt_clr;
  logic [3:0] w_rise;
  logic [3:0] w_new_irq;
  logic [7:0] w_rd_mux;
  logic       w_unused_data;

  // Wrapping subtraction keeps the window test correct for any base alignment.
  assign w_off     = BUS_ADDR - BASE_ADDR;
  assign w_in_win  = (w_off < 8'd4);
  assign w_rd      = w_in_win & ~BUS_WE;
  assign w_wr      = w_in_win & BUS_WE;
  assign w_evt_clr = (w_wr && (w_off[1:0] == OffEvent)) ? BUS_DATA[3:0] : 4'h0;
  assign w_rise    = r_db & ~r_db_prev;
  assign w_new_irq = w_rise & ~r_evt & r_mask;

  assign w_unused_data = ^BUS_DATA[7:4];

  always_comb begin
    w_rd_mux = 8'h00;
    unique case (w_off[1:0])
      OffSwitch: w_rd_mux = r_sw_s2;
      OffEvent:  w_rd_mux = {4'h0, r_evt};
      OffLevel:  w_rd_mux = {4'h0, r_db};
      OffMask:   w_rd_mux = {4'h0, r_mask};
      default:   w_rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sw_s1  <= 8'h00;
      r_sw_s2  <= 8'h00;
      r_btn_s1 <= 4'h0;
      r_btn_s2 <= 4'h0;
    end else begin
      r_sw_s1  <= SWITCHES;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= BUTTONS;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Any return of the synchronised level to the accepted level restarts the count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_db <= 4'h0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_btn_s2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CntLast) begin
          r_db[i]  <= r_btn_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_db_prev <= 4'h0;
      r_evt     <= 4'h0;
      r_mask    <= 4'hF;
      r_raise   <= 1'b0;
    end else begin
      r_db_prev <= r_db;
      // A press landing on the same edge as a W1C wins.
      r_evt     <= (r_evt & ~w_evt_clr) | w_rise;
      if (w_wr && (w_off[1:0] == OffMask)) begin
        r_mask <= BUS_DATA[3:0];
      end
      if (|w_new_irq) begin
        r_raise <= 1'b1;
      end else if (BUS_INTERRUPT_ACK) begin
        r_raise <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_data <= 8'h00;
      r_rd_oe   <= 1'b0;
    end else begin
      r_rd_oe <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_rd_mux;
      end
    end
  end

  assign BUS_DATA            = r_rd_oe ? r_rd_data : 8'hzz;
  assign BUS_INTERRUPT_RAISE = r_raise;

endmodule

// File: tb/tb_button_switch_bus.sv
// Directed bench for button_switch_bus with DEBOUNCE_CYCLES=4; a pulled-up data bus reads
// 8'hFF whenever nobody drives it.
module tb_button_switch_bus;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       we;
  logic [7:0] switches;
  logic [3:0] buttons;
  logic       raise;
  logic       ack;
  logic [7:0] drv;
  logic       drv_en;
  tri1  [7:0] bus_data;

  int n_vec = 0;
  int n_err = 0;

  assign bus_data = drv_en ? drv : 8'hzz;

  always #5 clk = ~clk;

  button_switch_bus #(
    .BASE_ADDR      (8'hC0),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (20)
  ) dut (
    .CLK                (clk),
    .RESET              (rst),
    .BUS_ADDR           (addr),
    .BUS_DATA           (bus_data),
    .BUS_WE             (we),
    .SWITCHES           (switches),
    .BUTTONS            (buttons),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
    addr = a;
    we   = 1'b0;
    tick(1);
    chk(tag, bus_data, exp);
    addr = 8'h00;
    tick(1);
    chk({tag, "_release"}, bus_data, 8'hFF);
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr   = a;
    we     = 1'b1;
    drv    = d;
    drv_en = 1'b1;
    tick(1);
    drv_en = 1'b0;
    we     = 1'b0;
    addr   = 8'h00;
    #1;
    chk("wr_no_drive", bus_data, 8'hFF);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; buttons = 4'h0; switches = 8'h00;
    addr = 8'h00; we = 1'b0; drv = 8'h00; drv_en = 1'b0;
    tick(2);
    chk("rst_raise", {7'b0, raise}, 8'h00);
    chk("rst_bus", bus_data, 8'hFF);
    rst = 1'b0;
    bus_read(8'hC3, 8'h0F, "rst_mask");
    bus_read(8'hC1, 8'h00, "rst_evt");
    bus_read(8'hC2, 8'h00, "rst_db");

    // Switches: two synchroniser edges, then one read cycle.
    switches = 8'hA5; addr = 8'hC0;
    tick(2);
    chk("sw_sync_lat", bus_data, 8'h00);
    tick(1);
    chk("sw_a5", bus_data, 8'hA5);
    addr = 8'hD0;
    tick(1);
    chk("sw_one_cycle", bus_data, 8'hFF);
    tick(1);
    chk("out_of_window", bus_data, 8'hFF);
    addr = 8'h00;

    // Three-cycle glitch on button 0 never debounces.
    buttons = 4'b0001;
    tick(3);
    buttons = 4'b0000;
    tick(8);
    chk("glitch_raise", {7'b0, raise}, 8'h00);
    bus_read(8'hC2, 8'h00, "glitch_db");
    bus_read(8'hC1, 8'h00, "glitch_evt");

    // Button 2: DB at edge 6, EVT/RAISE at edge 7.
    buttons = 4'b0100;
    tick(5);
    addr = 8'hC2;
    tick(1);
    chk("db_before", bus_data, 8'h00);
    chk("raise_before", {7'b0, raise}, 8'h00);
    tick(1);
    chk("db_set", bus_data, 8'h04);
    chk("raise_set", {7'b0, raise}, 8'h01);
    addr = 8'hC1;
    tick(1);
    chk("evt_set", bus_data, 8'h04);
    addr = 8'h00;
    tick(1);
    chk("evt_release", bus_data, 8'hFF);
    tick(1);
    buttons = 4'b0000;
    tick(8);
    bus_read(8'hC2, 8'h00, "db_fall");
    chk("raise_hold_fall", {7'b0, raise}, 8'h01);
    bus_read(8'hC1, 8'h04, "evt_no_fall");

    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_clr", {7'b0, raise}, 8'h00);
    bus_write(8'hC1, 8'h04);
    bus_read(8'hC1, 8'h00, "w1c");

    bus_write(8'hC3, 8'h01);
    bus_read(8'hC3, 8'h01, "mask_rd");
    bus_write(8'hC0, 8'hFF);
    bus_read(8'hC0, 8'hA5, "sw_wr_ignored");
    buttons = 4'b0010;
    tick(8);
    chk("masked_raise", {7'b0, raise}, 8'h00);
    bus_read(8'hC1, 8'h02, "masked_evt");
    buttons = 4'b0000;
    tick(8);
    buttons = 4'b0001;
    tick(8);
    chk("enabled_raise", {7'b0, raise}, 8'h01);
    bus_read(8'hC1, 8'h03, "evt_b0");
    buttons = 4'b0000;
    tick(8);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_clr2", {7'b0, raise}, 8'h00);
    bus_write(8'hC1, 8'h0F);
    bus_write(8'hC3, 8'h0F);
    bus_read(8'hC1, 8'h00, "evt_clr_all");

    // W1C of bit 3 on the edge that sets EVT[3].
    buttons = 4'b1000;
    tick(6);
    bus_write(8'hC1, 8'h08);
    bus_read(8'hC1, 8'h08, "w1c_vs_set");
    chk("raise_b3", {7'b0, raise}, 8'h01);
    buttons = 4'b0000;
    tick(8);

    // ACK on the edge that sets enabled EVT[2].
    buttons = 4'b0100;
    tick(6);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    chk("ack_vs_evt", {7'b0, raise}, 8'h01);
    bus_read(8'hC1, 8'h0C, "evt_b2b3");
    buttons = 4'b0000;
    tick(8);
    bus_write(8'hC3, 8'h07);

    // Reset mid-debounce and during a read.
    buttons = 4'b0001;
    tick(3);
    addr = 8'hC0;
    tick(1);
    chk("pre_rst_rd", bus_data, 8'hA5);
    rst = 1'b1;
    tick(1);
    chk("rst_rd_release", bus_data, 8'hFF);
    chk("rst_raise_mid", {7'b0, raise}, 8'h00);
    tick(1);
    rst = 1'b0;
    addr = 8'h00;
    tick(6);
    chk("rst_db_restart", {7'b0, raise}, 8'h00);
    tick(1);
    chk("rst_evt_raise", {7'b0, raise}, 8'h01);
    bus_read(8'hC1, 8'h01, "rst_evt_cleared");
    bus_read(8'hC3, 8'h0F, "rst_mask_back");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
